// File: rtl/seq_magnitude_comparator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmp_pkg: shared FSM state type and signed-to-offset-binary helper.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package cmp_pkg;

    localparam int CMP_MAX_WIDTH = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // Flipping the MSB maps two's-complement ordering onto unsigned ordering.
    function automatic logic [CMP_MAX_WIDTH-1:0] msb_flip(
        input logic [CMP_MAX_WIDTH-1:0] v,
        input int unsigned              w
    );
        return v ^ (CMP_MAX_WIDTH'(1) << (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_magnitude_comparator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_magnitude_comparator_if: start/busy/done handshake and result bus.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             agb;
    logic             alb;
    logic             aeb;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, agb, alb, aeb
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, agb, alb, aeb
    );
endinterface
`default_nettype wire

// File: rtl/seq_magnitude_comparator_digit_cmp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | digit_cmp: combinational unsigned compare of one DIGIT-bit slice.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  wire logic [DIGIT-1:0] a_i,
    input  wire logic [DIGIT-1:0] b_i,
    output logic                  gt_o,
    output logic                  lt_o
);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
endmodule
`default_nettype wire

// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_magnitude_comparator: digit-serial MSB-first magnitude compare with  |
// | early exit. Rev 1.0                                                      |
// +--------------------------------------------------------------------------+
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    seq_magnitude_comparator_if.slave  bus_if
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0 ||
            WIDTH > CMP_MAX_WIDTH) begin : g_bad_params
            $error("seq_magnitude_comparator: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    cmp_state_t       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             agb_q, agb_d, alb_q, alb_d, aeb_q, aeb_d;

    logic [DIGIT-1:0] w_a_dig, w_b_dig;
    logic             w_gt, w_lt;
    logic             w_accept;

    assign w_accept = (state_q == IDLE) && bus_if.start;

    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_q == IDXW'(k)) begin
                w_a_dig = a_q[k*DIGIT +: DIGIT];
                w_b_dig = b_q[k*DIGIT +: DIGIT];
            end
        end
    end

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .a_i  (w_a_dig),
        .b_i  (w_b_dig),
        .gt_o (w_gt),
        .lt_o (w_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus_if.start) state_d = CMP;
            CMP:     if (w_gt || w_lt || (idx_q == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_if.busy = (state_q != IDLE);
        bus_if.done = (state_q == DONE);
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        idx_d = idx_q;
        agb_d = agb_q;
        alb_d = alb_q;
        aeb_d = aeb_q;
        if (w_accept) begin
            a_d   = bus_if.signed_mode ?
                    WIDTH'(msb_flip(CMP_MAX_WIDTH'(bus_if.a), WIDTH)) : bus_if.a;
            b_d   = bus_if.signed_mode ?
                    WIDTH'(msb_flip(CMP_MAX_WIDTH'(bus_if.b), WIDTH)) : bus_if.b;
            idx_d = IDXW'(NDIG - 1);
            agb_d = 1'b0;
            alb_d = 1'b0;
            aeb_d = 1'b0;
        end else if (state_q == CMP) begin
            if (w_gt) begin
                agb_d = 1'b1;
            end else if (w_lt) begin
                alb_d = 1'b1;
            end else if (idx_q == '0) begin
                aeb_d = 1'b1;
            end else begin
                idx_d = idx_q - IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            agb_q <= 1'b0;
            alb_q <= 1'b0;
            aeb_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            a_q   <= a_d;
            b_q   <= b_d;
            agb_q <= agb_d;
            alb_q <= alb_d;
            aeb_q <= aeb_d;
        end
    end

    assign bus_if.agb = agb_q;
    assign bus_if.alb = alb_q;
    assign bus_if.aeb = aeb_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_magnitude_comparator: vector table, handshake/reset sequences and |
// | exhaustive 4-bit sweeps against a scoreboard. Rev 1.0                    |
// +--------------------------------------------------------------------------+
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    logic        st [3];
    logic        sm;
    logic [15:0] a_s, b_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_magnitude_comparator_if #(.WIDTH(16)) if16 ();
    seq_magnitude_comparator_if #(.WIDTH(4))  if41 ();
    seq_magnitude_comparator_if #(.WIDTH(4))  if44 ();

    assign if16.start = st[0];  assign if16.signed_mode = sm;
    assign if16.a = a_s;        assign if16.b = b_s;
    assign if41.start = st[1];  assign if41.signed_mode = sm;
    assign if41.a = a_s[3:0];   assign if41.b = b_s[3:0];
    assign if44.start = st[2];  assign if44.signed_mode = sm;
    assign if44.a = a_s[3:0];   assign if44.b = b_s[3:0];

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst(rst), .bus_if(if16.slave));
    seq_magnitude_comparator #(.WIDTH(4),  .DIGIT(1)) u_dut41 (.clk(clk), .rst(rst), .bus_if(if41.slave));
    seq_magnitude_comparator #(.WIDTH(4),  .DIGIT(4)) u_dut44 (.clk(clk), .rst(rst), .bus_if(if44.slave));

    logic       dn [3];
    logic       bz [3];
    logic [2:0] fl [3];
    assign dn[0] = if16.done;  assign bz[0] = if16.busy;  assign fl[0] = {if16.agb, if16.alb, if16.aeb};
    assign dn[1] = if41.done;  assign bz[1] = if41.busy;  assign fl[1] = {if41.agb, if41.alb, if41.aeb};
    assign dn[2] = if44.done;  assign bz[2] = if44.busy;  assign fl[2] = {if44.agb, if44.alb, if44.aeb};

    localparam logic [2:0] GT = 3'b100, LT = 3'b010, EQ = 3'b001;

    typedef struct {
        int         sel;
        logic [2:0] fl;
        int         due;
    } exp_t;

    typedef struct {
        logic        smv;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    exp_t sb [$];
    exp_t e_m;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest pending compare.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dn[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_done dut%0d: done=1 with nothing pending, expected 0 (cycle %0d)", k, cyc);
                end else begin
                    e_m = sb.pop_front();
                    chk("done_dut_index", k, e_m.sel);
                    chk("result_flags", fl[k], e_m.fl);
                    chk("done_cycle", cyc, e_m.due);
                end
            end
        end
    end

    task automatic run_one(input int sel, input logic smv, input logic [15:0] av,
                           input logic [15:0] bv, input logic [2:0] ef, input int lat);
        exp_t e;
        @(posedge clk); #1;
        sm = smv; a_s = av; b_s = bv; st[sel] = 1'b1;
        e.sel = sel; e.fl = ef; e.due = cyc + lat;
        sb.push_back(e);
        @(posedge clk); #1;
        st[sel] = 1'b0;
        a_s = 16'($urandom); b_s = 16'($urandom); sm = ~smv;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", c), bz[sel], (c <= lat));
            if (c == lat + 1) begin
                chk("flags_held", fl[sel], ef);
                chk("done_low_after", dn[sel], 0);
            end
        end
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    vec_t vt [11];
    int   c0;
    int   ia, ib, lat;
    logic [2:0] ef;
    logic [3:0] x;

    initial begin
        vt[0]  = '{1'b0, 16'hA000, 16'h9FFF, GT, 2};
        vt[1]  = '{1'b0, 16'h1234, 16'h1234, EQ, 5};
        vt[2]  = '{1'b1, 16'hFFFF, 16'h0001, LT, 2};
        vt[3]  = '{1'b0, 16'hFFFF, 16'h0001, GT, 2};
        vt[4]  = '{1'b1, 16'h8000, 16'h7FFF, LT, 2};
        vt[5]  = '{1'b0, 16'h0001, 16'h0002, LT, 5};
        vt[6]  = '{1'b0, 16'h1230, 16'h1240, LT, 4};
        vt[7]  = '{1'b1, 16'h8000, 16'h8000, EQ, 5};
        vt[8]  = '{1'b0, 16'h12F0, 16'h1200, GT, 4};
        vt[9]  = '{1'b1, 16'hFFFE, 16'hFFFF, LT, 5};
        vt[10] = '{1'b0, 16'h0000, 16'hFFFF, LT, 2};

        for (int k = 0; k < 3; k++) st[k] = 1'b0;
        sm = 1'b0; a_s = '0; b_s = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_busy%0d", k), bz[k], 0);
            chk($sformatf("reset_done%0d", k), dn[k], 0);
            chk($sformatf("reset_flags%0d", k), fl[k], 0);
        end
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 11; i++)
            run_one(0, vt[i].smv, vt[i].a, vt[i].b, vt[i].fl, vt[i].lat);

        // start held high; operands change while busy; start during DONE is ignored
        @(posedge clk); #1;
        sm = 1'b0; a_s = 16'h0005; b_s = 16'h0003; st[0] = 1'b1; c0 = cyc;
        sb.push_back('{0, GT, c0 + 5});
        sb.push_back('{0, LT, c0 + 11});
        @(posedge clk); #1;
        a_s = 16'h0003; b_s = 16'h0005;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_busy_c%0d", c), bz[0], (c != 6 && c <= 11));
            if (c == 6) begin
                chk("b2b_first_held", fl[0], GT);
                @(posedge clk); #1;
                st[0] = 1'b0;
                a_s = 16'hFFFF; b_s = 16'h0000;
            end
            if (c == 12) chk("b2b_second_held", fl[0], LT);
        end
        chk("b2b_drained", sb.size(), 0);
        sb.delete();

        // asynchronous reset in cycle 3 of an equal-operand compare
        @(posedge clk); #1;
        a_s = 16'h1234; b_s = 16'h1234; sm = 1'b0; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("pre_reset_busy", bz[0], 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", bz[0], 0);
        chk("midrst_done", dn[0], 0);
        chk("midrst_flags", fl[0], 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        run_one(0, 1'b0, 16'h0001, 16'h0002, LT, 5);

        // exhaustive sweeps of the 4-bit bit-serial and single-digit builds
        for (int sel = 1; sel <= 2; sel++) begin
            for (int s = 0; s < 2; s++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        ia = (s == 1 && a >= 8) ? a - 16 : a;
                        ib = (s == 1 && b >= 8) ? b - 16 : b;
                        ef = (ia > ib) ? GT : (ia < ib) ? LT : EQ;
                        x  = 4'(a ^ b);
                        if (sel == 2)  lat = 2;
                        else if (x[3]) lat = 2;
                        else if (x[2]) lat = 3;
                        else if (x[1]) lat = 4;
                        else           lat = 5;
                        run_one(sel, s[0], 16'(a), 16'(b), ef, lat);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands digit-serially, most-significant digit first, DIGIT bits per cycle, and stops early at the first unequal digit. The operands can be treated as unsigned or two's-complement. It replaces the single-cycle 4-bit comparator on wide datapaths where a full-width compare would limit clock rate. Operation uses a start/busy/done handshake, and results are registered and held.

## Interface
- WIDTH, 16: operand width in bits; ≥1.
- DIGIT, 4: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH, and WIDTH % DIGIT == 0. Any violation is an elaboration error.
- NDIG (localparam): WIDTH/DIGIT.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a compare; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement, 0 = unsigned; sampled with start.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the result becomes valid.
- agb  out  1  A > B.
- alb  out  1  A < B.
- aeb  out  1  A == B.

## Operation
- FSM states: IDLE, CMP, DONE.
- IDLE → CMP when start=1. On that edge:
  - capture A and B into internal registers;
  - if signed_mode=1, invert the MSB of both captured operands (offset-binary), so the compare is always unsigned;
  - set digit index idx = NDIG-1;
  - clear agb/alb/aeb to 0.
- In CMP, compare digit idx (bits idx*DIGIT+DIGIT-1 : idx*DIGIT) of the captured operands. At the edge:
  - digit A > digit B: agb=1, go to DONE;
  - digit A < digit B: alb=1, go to DONE;
  - digits equal and idx==0: aeb=1, go to DONE;
  - otherwise: idx = idx-1, stay in CMP.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Result flags are one-hot once valid. They hold their value until the next start is accepted or rst is asserted.
- start is ignored in CMP and DONE; it is not queued. Live A, B and signed_mode are ignored outside the accepting edge.
- Back-to-back operation: start held high continuously gives one compare every (latency+1) cycles, accepted in IDLE.
- The idx counter is max(1, $clog2(NDIG)) bits wide. It never wraps, because CMP leaves the state at idx==0.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- If the first unequal digit is j digits below the top (j=0 is the MSB digit), done and the valid flags appear in cycle j+2.
- Equal operands: done in cycle NDIG+1, which is the maximum latency. Minimum latency is 2.
- busy is high from cycle 1 through the done cycle inclusive, and low in the cycle after done.
- Reset values: state IDLE; busy=0, done=0, agb=0, alb=0, aeb=0; idx=0; operand registers 0.
- rst asserted mid-compare (CMP or DONE) takes effect immediately and asynchronously: all outputs go to 0 and no done pulse is produced. After release the block is in IDLE and accepts start on the first edge.
- DIGIT == WIDTH degenerates to a fixed 2-cycle latency. DIGIT == 1 gives a bit-serial compare.

## Structure
- Shared package cmp_pkg:
  - state enum cmp_state_t {IDLE, CMP, DONE};
  - function msb_flip(), used for the signed-to-offset conversion.
- One sub-module, digit_cmp: purely combinational, parameter DIGIT, inputs a and b, outputs gt and lt. It is instantiated once, and its inputs are muxed by idx.
- The top level holds the FSM, idx counter, operand registers and result registers.

## Test plan
All scenarios use WIDTH=16 and DIGIT=4 unless stated.
- Unsigned, top digit differs: A=0xA000, B=0x9FFF → done in cycle 2; agb=1, alb=0, aeb=0.
- Equal operands: A=B=0x1234 → done in cycle 5; aeb=1; busy high cycles 1–5.
- Signed vs unsigned, A=0xFFFF, B=0x0001:
  - signed_mode=1 → alb=1, done in cycle 2;
  - signed_mode=0 → agb=1.
  - Also signed A=0x8000, B=0x7FFF → alb=1.
- Handshake, A=0x0005, B=0x0003:
  - start held high, with A/B changed while busy → result reflects only the captured operands; exactly one done per compare;
  - next accept happens only after returning to IDLE;
  - start in the DONE cycle is ignored.
- Reset mid-compare: A=B=0x1234; assert rst in cycle 3 → all outputs 0 immediately and no done. After release, start with A=0x0001, B=0x0002 → alb=1 in cycle 5.
- Exhaustive configurations, all 256 (A,B) pairs in both modes, checked against a golden model, with latency checked per pair:
  - WIDTH=4, DIGIT=1;
  - WIDTH=4, DIGIT=4.
